debug_trace_sink: RTL and testbench
===================================

DEBUG_TRACE_SINK -- requirements
Module: debug_trace_sink

Interface
REQ-001 SHALL use parameter DEPTH, default 16, trace FIFO entries (power of two, 4..64).
REQ-002 SHALL use parameter MAXBEAT, default 16, maximum beats per packet before a forced new packet.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port MRST, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports TPE (input, 1) and TP (input, 32): trace beat valid and trace beat data from the debug wrapper.
REQ-006 SHALL have port EV, input, 8: event code from the debug wrapper.
REQ-007 SHALL have ports cfg_req (input, 1), cfg_idx (input, 8), cfg_data (input, 31) and cfg_sel (input, 2): configuration write request.
REQ-008 SHALL have ports cfg_ack (output, 1), cfg_err (output, 1) and cfg_busy (output, 1): configuration status.
REQ-009 SHALL have ports DCP (output, 32) and Sel (output, 2): debug control port driven toward the wrapper.
REQ-010 SHALL have ports rd_valid (output, 1), rd_ready (input, 1), rd_data (output, 32), rd_ev (output, 8) and rd_sop (output, 1): trace read port.
REQ-011 SHALL have ports fill (output, 7), ovf (output, 1) and drop_cnt (output, 16): FIFO status.

Function
REQ-012 SHALL run a configuration sequencer with states IDLE, HDR, DATA, GAP; cfg_busy = (state != IDLE).
REQ-013 In IDLE, cfg_req with cfg_idx in 32..47 SHALL go to HDR; out-of-range cfg_idx SHALL give a 1-cycle cfg_err pulse, no DCP activity, and stay in IDLE.
REQ-014 HDR SHALL drive DCP = {1'b1, 23'b0, cfg_idx} and Sel = cfg_sel; cfg_idx, cfg_data and cfg_sel SHALL be latched on acceptance.
REQ-015 DATA SHALL drive DCP = {1'b0, cfg_data latched}.
REQ-016 GAP SHALL drive DCP = 0 and pulse cfg_ack for 1 cycle, then return to IDLE; request to cfg_ack latency is exactly 3 cycles.
REQ-017 DCP SHALL be 0 in IDLE; Sel SHALL hold its last written value; cfg_req SHALL be ignored while cfg_busy.
REQ-018 Each cycle with TPE=1 SHALL be one beat; a beat is SOP when the previous cycle had TPE=0, or when the packet beat counter has reached MAXBEAT (the counter then restarts at 1).
REQ-019 Each beat SHALL write an entry {sop, ev, TP}; ev is EV sampled on the packet's SOP beat and held for the rest of the packet.
REQ-020 Write SHALL be permitted when fill < DEPTH, or when fill == DEPTH and a pop occurs in the same cycle.
REQ-021 A beat refused for lack of space SHALL set ovf (sticky) and increment drop_cnt, saturating at 16'hFFFF.
REQ-022 After a refused beat, all remaining beats of that packet SHALL be dropped and counted, up to the next SOP.
REQ-023 The read port SHALL be show-ahead: rd_valid = (fill != 0), with rd_data/rd_ev/rd_sop presenting the head entry; pop on rd_valid && rd_ready.
REQ-024 rd_data/rd_ev/rd_sop SHALL be 0 when the FIFO is empty.
REQ-025 Push and pop in the same cycle SHALL leave fill unchanged.
REQ-026 fill SHALL range 0..DEPTH; read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 MRST=1 at an edge SHALL force: state=IDLE, DCP=0, Sel=0, cfg_ack=0, cfg_err=0, fill=0, rd_valid=0, ovf=0, drop_cnt=0, beat counter=0, drop flag=0.
REQ-028 Reset mid-sequence SHALL abandon the write with no cfg_ack.
REQ-029 Reset SHALL discard FIFO contents.
REQ-030 The first TPE beat after reset SHALL be SOP.

Structure
REQ-031 A shared package SHALL hold the state encoding, CFG_LO=32, CFG_HI=47, and the DCP strobe bit index 31.
REQ-032 The FIFO SHALL be one sub-module, trace_fifo (parameterised width/depth, show-ahead); framing, drop logic and the sequencer SHALL reside in the top.

Verification
REQ-033 cfg_req with idx=32, data=31'h1, sel=2'b11 -> DCP 0x80000020, 0x00000001, 0x00000000 on consecutive cycles, Sel=3, cfg_ack on cycle 3.
REQ-034 cfg_req with idx=48 -> cfg_err pulse, DCP stays 0, cfg_busy stays 0.
REQ-035 A 4-beat TPE burst with EV=4, rd_ready=1 -> 4 reads, ev=4, rd_sop only on the first.
REQ-036 20 consecutive TPE beats (MAXBEAT=16) -> rd_sop on beat 1 and beat 17.
REQ-037 rd_ready=0 with a 20-beat burst, DEPTH=16 -> fill=16, drop_cnt=4, ovf=1; after draining, a fresh burst is accepted with SOP.
REQ-038 Reset asserted during DATA -> next cycle DCP=0, no cfg_ack; a new cfg_req is accepted afterwards.

Source files
------------

// File: rtl/debug_trace_sink_pkg.sv
// Shared definitions for the debug trace sink: sequencer states, config index window,
// debug control port strobe position and the trace FIFO entry layout.
package debug_trace_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } cfg_state_t;

  localparam logic [7:0] CFG_LO      = 8'd32;
  localparam logic [7:0] CFG_HI      = 8'd47;
  localparam int         DCP_STB_BIT = 31;

  typedef struct packed {
    logic        sop;
    logic [7:0]  ev;
    logic [31:0] dat;
  } trace_entry_t;

  function automatic logic idx_in_range(input logic [7:0] idx);
    return (idx >= CFG_LO) && (idx <= CFG_HI);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO, head visible combinationally (zero when empty); push and pop take effect
// on the next edge. The caller only pushes when there is room (or a same-cycle pop frees it).
module trace_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdat,
  output logic [$clog2(DEPTH):0] o_fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_fill;
  logic             w_empty;
  logic             w_pop;

  assign w_empty = (r_fill == '0);
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      unique case ({i_push, w_pop})
        2'b10:   r_fill <= r_fill + FILL_ONE;
        2'b01:   r_fill <= r_fill - FILL_ONE;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until fill says so.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdat;
  end

  assign o_rdat = w_empty ? '0 : r_mem[r_rptr];
  assign o_fill = r_fill;

endmodule

// File: rtl/debug_trace_sink.sv
// Debug trace sink: 3-cycle config write sequencer toward the wrapper, plus trace beat framing
// into a show-ahead FIFO; beats arriving with no room are dropped for the rest of their packet.
module debug_trace_sink #(
  parameter int DEPTH   = 16,
  parameter int MAXBEAT = 16
) (
  input  logic        clk,
  input  logic        MRST,
  input  logic        TPE,
  input  logic [31:0] TP,
  input  logic [7:0]  EV,
  input  logic        cfg_req,
  input  logic [7:0]  cfg_idx,
  input  logic [30:0] cfg_data,
  input  logic [1:0]  cfg_sel,
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic        cfg_busy,
  output logic [31:0] DCP,
  output logic [1:0]  Sel,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic [7:0]  rd_ev,
  output logic        rd_sop,
  output logic [6:0]  fill,
  output logic        ovf,
  output logic [15:0] drop_cnt
);

  import debug_trace_sink_pkg::*;

  localparam int BW = $clog2(MAXBEAT + 1);
  localparam int FW = $clog2(DEPTH) + 1;
  localparam logic [BW-1:0] MAXB     = BW'(MAXBEAT);
  localparam logic [BW-1:0] BEAT_ONE = BW'(1);
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);

  cfg_state_t  r_state;
  cfg_state_t  w_next;
  logic [7:0]  r_idx;
  logic [30:0] r_data;
  logic [1:0]  r_sel;
  logic        r_err;
  logic        w_accept;
  logic        w_reject;
  logic [31:0] w_dcp;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_dcp    = '0;
    cfg_ack  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cfg_req) begin
          if (idx_in_range(cfg_idx)) begin
            w_accept = 1'b1;
            w_next   = ST_HDR;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_HDR: begin
        w_dcp[DCP_STB_BIT] = 1'b1;
        w_dcp[7:0]         = r_idx;
        w_next             = ST_DATA;
      end
      ST_DATA: begin
        w_dcp  = {1'b0, r_data};
        w_next = ST_GAP;
      end
      ST_GAP: begin
        cfg_ack = 1'b1;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (MRST) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_sel   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_reject;
      if (w_accept) begin
        r_idx  <= cfg_idx;
        r_data <= cfg_data;
        r_sel  <= cfg_sel;
      end
    end
  end

  assign DCP      = w_dcp;
  assign Sel      = r_sel;
  assign cfg_err  = r_err;
  assign cfg_busy = (r_state != ST_IDLE);

  logic          r_prev_tpe;
  logic [BW-1:0] r_beat_cnt;
  logic [7:0]    r_ev;
  logic          r_drop;
  logic          r_ovf;
  logic [15:0]   r_drop_cnt;
  logic          w_sop;
  logic [7:0]    w_ev;
  logic          w_dropping;
  logic          w_pop;
  logic          w_room;
  logic          w_push;
  logic          w_refuse;
  logic [FW-1:0] w_fill;
  trace_entry_t  w_wr;
  trace_entry_t  w_rd;

  assign w_sop      = !r_prev_tpe || (r_beat_cnt == MAXB);
  assign w_ev       = w_sop ? EV : r_ev;
  // A new SOP gives a previously dropped packet's successor a fresh chance.
  assign w_dropping = w_sop ? 1'b0 : r_drop;
  assign w_pop      = rd_valid && rd_ready;
  assign w_room     = (w_fill < FULL_LVL) || w_pop;
  assign w_push     = TPE && !w_dropping && w_room;
  assign w_refuse   = TPE && !w_push;
  assign w_wr       = '{sop: w_sop, ev: w_ev, dat: TP};

  always_ff @(posedge clk) begin
    if (MRST) begin
      r_prev_tpe <= 1'b0;
      r_beat_cnt <= '0;
      r_ev       <= '0;
      r_drop     <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_prev_tpe <= TPE;
      if (TPE) begin
        r_beat_cnt <= w_sop ? BEAT_ONE : (r_beat_cnt + BEAT_ONE);
        r_ev       <= w_ev;
        r_drop     <= w_refuse;
      end
      if (w_refuse) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  trace_fifo #(
    .WIDTH($bits(trace_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .i_rst  (MRST),
    .i_push (w_push),
    .i_wdat (w_wr),
    .i_pop  (w_pop),
    .o_rdat (w_rd),
    .o_fill (w_fill)
  );

  assign rd_valid = (w_fill != '0);
  assign rd_data  = w_rd.dat;
  assign rd_ev    = w_rd.ev;
  assign rd_sop   = w_rd.sop;
  assign fill     = 7'(w_fill);
  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_debug_trace_sink.sv
// Self-checking bench for debug_trace_sink: directed config/framing scenarios plus randomized
// trace traffic compared against a queue-based packet model.
module tb_debug_trace_sink;

  localparam int DEPTH   = 16;
  localparam int MAXBEAT = 16;

  logic        clk = 1'b0;
  logic        MRST, TPE, cfg_req, rd_ready;
  logic [31:0] TP;
  logic [7:0]  EV, cfg_idx;
  logic [30:0] cfg_data;
  logic [1:0]  cfg_sel;
  logic        cfg_ack, cfg_err, cfg_busy, rd_valid, rd_sop, ovf;
  logic [31:0] DCP, rd_data;
  logic [1:0]  Sel;
  logic [7:0]  rd_ev;
  logic [6:0]  fill;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [40:0] m_q[$];
  logic        m_prev;
  int          m_plen;
  logic [7:0]  m_ev;
  logic        m_drop;
  logic        m_ovf;
  logic [15:0] m_dcnt;
  logic [1:0]  last_sel;

  always #5 clk = ~clk;

  debug_trace_sink #(.DEPTH(DEPTH), .MAXBEAT(MAXBEAT)) dut (
    .clk(clk), .MRST(MRST), .TPE(TPE), .TP(TP), .EV(EV),
    .cfg_req(cfg_req), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_sel(cfg_sel),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .cfg_busy(cfg_busy),
    .DCP(DCP), .Sel(Sel),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_ev(rd_ev), .rd_sop(rd_sop),
    .fill(fill), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  // Packet-level view of one clock edge, using the inputs currently driven.
  task automatic model_step();
    logic pop, room, sop;
    if (MRST) begin
      m_q.delete();
      m_prev = 1'b0; m_plen = 0; m_ev = '0; m_drop = 1'b0; m_ovf = 1'b0; m_dcnt = '0;
      return;
    end
    pop  = (m_q.size() != 0) && rd_ready;
    room = (m_q.size() < DEPTH) || pop;
    if (pop) void'(m_q.pop_front());
    if (TPE) begin
      sop    = !m_prev || (m_plen == MAXBEAT);
      m_plen = sop ? 1 : m_plen + 1;
      if (sop) begin
        m_ev   = EV;
        m_drop = 1'b0;
      end
      if (!m_drop && room) m_q.push_back({sop, m_ev, TP});
      else begin
        m_ovf  = 1'b1;
        m_drop = 1'b1;
        if (m_dcnt != 16'hFFFF) m_dcnt++;
      end
    end
    m_prev = TPE;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_cfg_write();
    logic [7:0] idx; logic [30:0] dat; logic [1:0] sel; logic [31:0] hdr;
    for (int v = 0; v < 4; v++) begin
      idx = (v == 0) ? 8'd32 : 8'(32 + $urandom_range(15));
      dat = (v == 0) ? 31'h1 : 31'($urandom);
      sel = (v == 0) ? 2'b11 : 2'($urandom_range(3));
      hdr = {1'b1, 23'b0, idx};
      cfg_req = 1'b1; cfg_idx = idx; cfg_data = dat; cfg_sel = sel;
      cycle();
      n_checks++; if (DCP !== hdr) $display("FAIL cfg_hdr_dcp got=%h exp=%h", DCP, hdr); else n_pass++;
      n_checks++; if (Sel !== sel) $display("FAIL cfg_hdr_sel got=%0d exp=%0d", Sel, sel); else n_pass++;
      n_checks++; if (cfg_busy !== 1'b1) $display("FAIL cfg_hdr_busy got=%b exp=1", cfg_busy); else n_pass++;
      cfg_idx = 8'(32 + $urandom_range(15)); cfg_data = 31'($urandom); cfg_sel = 2'($urandom_range(3));
      cycle();
      n_checks++; if (DCP !== {1'b0, dat}) $display("FAIL cfg_data_dcp got=%h exp=%h", DCP, {1'b0, dat}); else n_pass++;
      n_checks++; if (cfg_ack !== 1'b0) $display("FAIL cfg_data_ack got=%b exp=0", cfg_ack); else n_pass++;
      cfg_req = 1'b0;
      cycle();
      n_checks++; if (DCP !== 32'h0) $display("FAIL cfg_gap_dcp got=%h exp=0", DCP); else n_pass++;
      n_checks++; if (cfg_ack !== 1'b1) $display("FAIL cfg_gap_ack got=%b exp=1", cfg_ack); else n_pass++;
      cycle();
      n_checks++; if (cfg_ack !== 1'b0 || cfg_busy !== 1'b0) $display("FAIL cfg_done ack=%b busy=%b exp 0/0", cfg_ack, cfg_busy); else n_pass++;
      n_checks++; if (Sel !== sel) $display("FAIL cfg_sel_hold got=%0d exp=%0d", Sel, sel); else n_pass++;
      last_sel = sel;
    end
  endtask

  task automatic test_cfg_err();
    logic [7:0] idx;
    for (int v = 0; v < 4; v++) begin
      case (v)
        0: idx = 8'd48;
        1: idx = 8'd31;
        2: idx = 8'($urandom_range(31));
        default: idx = 8'($urandom_range(255, 48));
      endcase
      cfg_req = 1'b1; cfg_idx = idx; cfg_data = 31'($urandom); cfg_sel = 2'($urandom_range(3));
      cycle();
      cfg_req = 1'b0;
      n_checks++; if (cfg_err !== 1'b1) $display("FAIL err_pulse idx=%0d got=%b exp=1", idx, cfg_err); else n_pass++;
      n_checks++; if (DCP !== 32'h0 || cfg_busy !== 1'b0) $display("FAIL err_idle dcp=%h busy=%b exp 0/0", DCP, cfg_busy); else n_pass++;
      cycle();
      n_checks++; if (cfg_err !== 1'b0) $display("FAIL err_one_cycle got=%b exp=0", cfg_err); else n_pass++;
      n_checks++; if (DCP !== 32'h0 || cfg_busy !== 1'b0 || cfg_ack !== 1'b0) $display("FAIL err_after dcp=%h busy=%b ack=%b exp 0", DCP, cfg_busy, cfg_ack); else n_pass++;
      n_checks++; if (Sel !== last_sel) $display("FAIL err_sel got=%0d exp=%0d", Sel, last_sel); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] tps[20];
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tps[i] = $urandom; TPE = 1'b1; TP = tps[i]; EV = 8'($urandom);
      cycle();
    end
    TPE = 1'b0;
    cycle();
    n_checks++; if (fill !== 7'd16) $display("FAIL ovf_fill got=%0d exp=16", fill); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd4) $display("FAIL ovf_drop_cnt got=%0d exp=4", drop_cnt); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", ovf); else n_pass++;
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== tps[i]) $display("FAIL ovf_drain[%0d] v=%b got=%h exp=%h", i, rd_valid, rd_data, tps[i]); else n_pass++;
      n_checks++; if (rd_sop !== (i == 0)) $display("FAIL ovf_drain_sop[%0d] got=%b", i, rd_sop); else n_pass++;
      cycle();
    end
    n_checks++; if (rd_valid !== 1'b0 || fill !== 7'd0) $display("FAIL ovf_empty v=%b fill=%0d exp 0/0", rd_valid, fill); else n_pass++;
    n_checks++; if (rd_data !== 32'h0 || rd_ev !== 8'h0 || rd_sop !== 1'b0) $display("FAIL empty_zero d=%h ev=%h sop=%b exp 0", rd_data, rd_ev, rd_sop); else n_pass++;
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tps[i] = $urandom; TPE = 1'b1; TP = tps[i]; EV = 8'h5A;
      cycle();
    end
    TPE = 1'b0;
    cycle();
    n_checks++; if (fill !== 7'd3) $display("FAIL fresh_fill got=%0d exp=3", fill); else n_pass++;
    n_checks++; if (rd_sop !== 1'b1 || rd_data !== tps[0] || rd_ev !== 8'h5A) $display("FAIL fresh_head sop=%b d=%h ev=%h exp 1/%h/5a", rd_sop, rd_data, rd_ev, tps[0]); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd4 || ovf !== 1'b1) $display("FAIL fresh_sticky drop=%0d ovf=%b exp 4/1", drop_cnt, ovf); else n_pass++;
  endtask

  task automatic test_reset();
    MRST = 1'b1; TPE = 1'b1; TP = $urandom; EV = 8'($urandom); rd_ready = 1'b0;
    cycle();
    cycle();
    n_checks++; if (DCP !== 32'h0 || Sel !== 2'd0) $display("FAIL rst_dcp_sel dcp=%h sel=%0d exp 0", DCP, Sel); else n_pass++;
    n_checks++; if (cfg_ack !== 1'b0 || cfg_err !== 1'b0 || cfg_busy !== 1'b0) $display("FAIL rst_cfg ack=%b err=%b busy=%b exp 0", cfg_ack, cfg_err, cfg_busy); else n_pass++;
    n_checks++; if (fill !== 7'd0 || rd_valid !== 1'b0) $display("FAIL rst_fifo fill=%0d v=%b exp 0", fill, rd_valid); else n_pass++;
    n_checks++; if (ovf !== 1'b0 || drop_cnt !== 16'd0) $display("FAIL rst_ovf ovf=%b drop=%0d exp 0", ovf, drop_cnt); else n_pass++;
    n_checks++; if (rd_data !== 32'h0 || rd_sop !== 1'b0) $display("FAIL rst_rd d=%h sop=%b exp 0", rd_data, rd_sop); else n_pass++;
    MRST = 1'b0;
  endtask

  // Beat i gets ev_at[i] on EV; reads collected with rd_ready held high.
  task automatic run_burst(input int n, output logic [40:0] got[$], output logic [31:0] tps[$],
                           output logic [7:0] evs[$]);
    got.delete(); tps.delete(); evs.delete();
    rd_ready = 1'b1;
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) begin
        TPE = 1'b1; TP = $urandom; EV = 8'($urandom);
        tps.push_back(TP); evs.push_back(EV);
      end else begin
        TPE = 1'b0;
      end
      cycle();
      if (rd_valid) got.push_back({rd_sop, rd_ev, rd_data});
    end
  endtask

  task automatic test_burst4();
    logic [40:0] got[$]; logic [31:0] tps[$]; logic [7:0] evs[$];
    logic [40:0] exp;
    run_burst(4, got, tps, evs);
    n_checks++; if (got.size() != 4) $display("FAIL burst4_count got=%0d exp=4", got.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      exp = {(i == 0), evs[0], tps[i]};
      n_checks++; if (got[i] !== exp) $display("FAIL burst4_beat[%0d] got=%h exp=%h", i, got[i], exp); else n_pass++;
    end
  endtask

  task automatic test_maxbeat();
    logic [40:0] got[$]; logic [31:0] tps[$]; logic [7:0] evs[$];
    logic [40:0] exp;
    run_burst(20, got, tps, evs);
    n_checks++; if (got.size() != 20) $display("FAIL maxbeat_count got=%0d exp=20", got.size()); else n_pass++;
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      exp = {(i == 0 || i == 16), (i < 16) ? evs[0] : evs[16], tps[i]};
      n_checks++; if (got[i] !== exp) $display("FAIL maxbeat_beat[%0d] got=%h exp=%h", i, got[i], exp); else n_pass++;
    end
  endtask

  task automatic test_cfg_reset_mid();
    TPE = 1'b0;
    cfg_req = 1'b1; cfg_idx = 8'd40; cfg_data = 31'h1234567; cfg_sel = 2'd2;
    cycle();
    cfg_req = 1'b0;
    cycle();
    n_checks++; if (DCP !== 32'h01234567) $display("FAIL rmid_data got=%h exp=01234567", DCP); else n_pass++;
    MRST = 1'b1;
    cycle();
    MRST = 1'b0;
    n_checks++; if (DCP !== 32'h0 || cfg_busy !== 1'b0 || Sel !== 2'd0) $display("FAIL rmid_abort dcp=%h busy=%b sel=%0d exp 0", DCP, cfg_busy, Sel); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (cfg_ack !== 1'b0) $display("FAIL rmid_no_ack[%0d] got=%b exp=0", i, cfg_ack); else n_pass++;
      cycle();
    end
    cfg_req = 1'b1; cfg_idx = 8'd33; cfg_data = 31'h7; cfg_sel = 2'd1;
    cycle();
    cfg_req = 1'b0;
    n_checks++; if (DCP !== 32'h80000021 || cfg_busy !== 1'b1) $display("FAIL rmid_new_hdr dcp=%h busy=%b exp 80000021/1", DCP, cfg_busy); else n_pass++;
    cycle();
    cycle();
    n_checks++; if (cfg_ack !== 1'b1) $display("FAIL rmid_new_ack got=%b exp=1", cfg_ack); else n_pass++;
    cycle();
  endtask

  task automatic test_random();
    logic [40:0] head;
    cfg_req = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      MRST     = ($urandom_range(199) == 0);
      TPE      = ($urandom_range(99) < 75);
      TP       = $urandom;
      EV       = 8'($urandom);
      rd_ready = (((i / 150) % 2) == 0) ? ($urandom_range(99) < 20) : ($urandom_range(99) < 85);
      cycle();
      head = (m_q.size() != 0) ? m_q[0] : '0;
      n_checks++; if (rd_valid !== (m_q.size() != 0) || fill !== 7'(m_q.size())) $display("FAIL rnd_fill[%0d] v=%b fill=%0d exp_fill=%0d", i, rd_valid, fill, m_q.size()); else n_pass++;
      n_checks++; if ({rd_sop, rd_ev, rd_data} !== head) $display("FAIL rnd_head[%0d] got=%h exp=%h", i, {rd_sop, rd_ev, rd_data}, head); else n_pass++;
      n_checks++; if (ovf !== m_ovf || drop_cnt !== m_dcnt) $display("FAIL rnd_drop[%0d] ovf=%b drop=%0d exp %b/%0d", i, ovf, drop_cnt, m_ovf, m_dcnt); else n_pass++;
    end
    MRST = 1'b0; TPE = 1'b0;
  endtask

  initial begin
    MRST = 1'b1; TPE = 1'b0; TP = '0; EV = '0; rd_ready = 1'b0;
    cfg_req = 1'b0; cfg_idx = '0; cfg_data = '0; cfg_sel = '0; last_sel = '0;
    cycle();
    cycle();
    MRST = 1'b0;
    cycle();
    test_cfg_write();
    test_cfg_err();
    test_overflow();
    test_reset();
    test_burst4();
    test_maxbeat();
    test_cfg_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
